// File: rtl/count_mon_pkg.sv
// Purpose: shared types and constants for count_wrap_monitor.
//   - state_e : monitor FSM states
//   - dir_e   : wrap filter encodings latched on arm
//   - filt_wrap(): applies the latched direction filter to raw wrap strobes
package count_mon_pkg;

   localparam int unsigned CNT_W_DEF = 4;
   localparam int unsigned EVT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      REPORT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DN   = 2'b10,
      DIR_BOTH = 2'b11
   } dir_e;

   // A wrap counts only if its direction is enabled by the filter
   function automatic logic filt_wrap(input logic up_wrap, input logic dn_wrap,
                                      input dir_e dir);
      logic up_en;
      logic dn_en;
      up_en = (dir == DIR_UP) || (dir == DIR_BOTH);
      dn_en = (dir == DIR_DN) || (dir == DIR_BOTH);
      return (up_wrap & up_en) | (dn_wrap & dn_en);
   endfunction

endpackage

// File: rtl/count_wrap_monitor_if.sv
// Purpose: completion report handshake between the monitor and its consumer.
//   evt_valid : report pending (monitor -> consumer)
//   evt_ready : consumer accepts report (consumer -> monitor)
//   evt_count : wraps counted since last arm (monitor -> consumer)
interface count_wrap_monitor_if #(
   parameter int unsigned EVT_W = 8
) ();

   logic             evt_valid;
   logic             evt_ready;
   logic [EVT_W-1:0] evt_count;

   modport master (
      output evt_valid,
      output evt_count,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_count,
      output evt_ready
   );

endinterface

// File: rtl/count_wrap_monitor_wrap_detect.sv
// Purpose: detects genuine counter wrap-arounds from the observed counter value
// and the controls that produced it.
//   clk, rst            : clock, async active-high reset
//   cnt_in              : observed counter value
//   cnt_load, cnt_up    : counter controls sampled on the same edge as the counter
//   up_wrap_c/dn_wrap_c : combinational wrap strobes for the current cycle
//   wrap_up/wrap_dn     : registered one-cycle wrap pulses
module wrap_detect #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cnt_in,
   input  logic             cnt_load,
   input  logic             cnt_up,
   output logic             up_wrap_c,
   output logic             dn_wrap_c,
   output logic             wrap_up,
   output logic             wrap_dn
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   logic [CNT_W-1:0] prev_cnt_q;
   logic             prev_load_q;
   logic             prev_up_q;
   logic             hist_vld_q;
   logic             wrap_up_q;
   logic             wrap_dn_q;

   // prev_* are the controls that produced the value now on cnt_in
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_cnt_q  <= CNT_ZERO;
         prev_load_q <= 1'b0;
         prev_up_q   <= 1'b0;
         hist_vld_q  <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_dn_q   <= 1'b0;
      end else begin
         prev_cnt_q  <= cnt_in;
         prev_load_q <= cnt_load;
         prev_up_q   <= cnt_up;
         hist_vld_q  <= 1'b1;
         wrap_up_q   <= up_wrap_c;
         wrap_dn_q   <= dn_wrap_c;
      end
   end

   // A load landing on 0 or max is not a wrap, hence the prev_load gate
   always_comb begin
      up_wrap_c = hist_vld_q & ~prev_load_q &  prev_up_q &
                  (prev_cnt_q == CNT_MAX)  & (cnt_in == CNT_ZERO);
      dn_wrap_c = hist_vld_q & ~prev_load_q & ~prev_up_q &
                  (prev_cnt_q == CNT_ZERO) & (cnt_in == CNT_MAX);
   end

   assign wrap_up = wrap_up_q;
   assign wrap_dn = wrap_dn_q;

endmodule

// File: rtl/count_wrap_monitor.sv
// Purpose: counts filtered counter wraps after an arm request and reports
// completion over a valid/ready handshake.
//   clk, rst          : clock, async active-high reset
//   cnt_in            : observed counter value
//   cnt_load, cnt_up  : counter controls, same cycle the counter samples them
//   arm               : start a new measurement (latches dir_sel, thresh)
//   dir_sel, thresh   : wrap filter and wrap target
//   evt_if            : report handshake (evt_valid/evt_ready/evt_count)
//   wrap_up, wrap_dn  : unfiltered registered wrap pulses
//   overflow          : sticky, filtered wrap seen while a report was pending
module count_wrap_monitor
   import count_mon_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned EVT_W = EVT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CNT_W-1:0]     cnt_in,
   input  logic                 cnt_load,
   input  logic                 cnt_up,
   input  logic                 arm,
   input  logic [1:0]           dir_sel,
   input  logic [EVT_W-1:0]     thresh,
   count_wrap_monitor_if.master evt_if,
   output logic                 wrap_up,
   output logic                 wrap_dn,
   output logic                 overflow
);

   logic up_wrap_c;
   logic dn_wrap_c;
   logic fwrap_c;

   state_e           state_q,     state_d;
   logic [EVT_W-1:0] evt_count_q, evt_count_d;
   logic [EVT_W-1:0] thresh_q,    thresh_d;
   dir_e             dir_q,       dir_d;
   logic             overflow_q,  overflow_d;
   logic             evt_valid_q, evt_valid_d;

   wrap_detect #(
      .CNT_W (CNT_W)
   ) u_wrap_detect (
      .clk       (clk),
      .rst       (rst),
      .cnt_in    (cnt_in),
      .cnt_load  (cnt_load),
      .cnt_up    (cnt_up),
      .up_wrap_c (up_wrap_c),
      .dn_wrap_c (dn_wrap_c),
      .wrap_up   (wrap_up),
      .wrap_dn   (wrap_dn)
   );

   assign fwrap_c = filt_wrap(up_wrap_c, dn_wrap_c, dir_q);

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         evt_count_q <= '0;
         thresh_q    <= '0;
         dir_q       <= DIR_NONE;
         overflow_q  <= 1'b0;
         evt_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         evt_count_q <= evt_count_d;
         thresh_q    <= thresh_d;
         dir_q       <= dir_d;
         overflow_q  <= overflow_d;
         evt_valid_q <= evt_valid_d;
      end
   end

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      evt_count_d = evt_count_q;
      thresh_d    = thresh_q;
      dir_d       = dir_q;
      overflow_d  = overflow_q;

      unique case (state_q)
         IDLE, ARMED: begin
            if (arm) begin
               // Restart wins over a same-cycle wrap
               evt_count_d = '0;
               overflow_d  = 1'b0;
               thresh_d    = thresh;
               dir_d       = dir_e'(dir_sel);
               state_d     = (thresh == '0) ? REPORT : ARMED;
            end else if ((state_q == ARMED) && fwrap_c) begin
               evt_count_d = evt_count_q + EVT_W'(1);
               if (evt_count_d == thresh_q) begin
                  state_d = REPORT;
               end
            end
         end
         REPORT: begin
            if (fwrap_c) begin
               overflow_d = 1'b1;
            end
            if (evt_ready_c()) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      evt_valid_d = (state_d == REPORT);
   end

   function automatic logic evt_ready_c();
      return evt_if.evt_ready;
   endfunction

   assign evt_if.evt_valid = evt_valid_q;
   assign evt_if.evt_count = evt_count_q;
   assign overflow         = overflow_q;

endmodule

// File: doc/count_wrap_monitor.md
# count_wrap_monitor

Downstream observer of the 4-bit load/up-down counter. Samples the counter output and the same load/direction controls the counter sees. Detects true wrap-around events (max→0 counting up, 0→max counting down; loads never count). After being armed, it counts selected wraps against a threshold and reports completion over a valid/ready handshake.

## Interface
- CNT_W, 4: width of observed counter value
- EVT_W, 8: width of wrap-event counter and threshold
- clk  in  1  rising-edge clock, shared with the counter
- rst  in  1  reset, asynchronous, active-high
- cnt_in  in  CNT_W  counter output (d_out of counter)
- cnt_load  in  1  counter load control, same signal/cycle the counter samples
- cnt_up  in  1  counter direction control (1 = up), same signal/cycle the counter samples
- arm  in  1  single-cycle request: start a new measurement
- dir_sel  in  2  wrap filter, latched on arm: 00 none, 01 up only, 10 down only, 11 both
- thresh  in  EVT_W  wrap count target, latched on arm
- evt_valid  out  1  measurement complete, held until accepted
- evt_ready  in  1  consumer accepts report
- evt_count  out  EVT_W  wraps counted since last arm
- wrap_up  out  1  one-cycle pulse per detected up-wrap (unfiltered)
- wrap_dn  out  1  one-cycle pulse per detected down-wrap (unfiltered)
- overflow  out  1  sticky: a filtered wrap occurred while in REPORT; cleared by accepted arm

## Operation
- History: each cycle register prev_cnt <= cnt_in, prev_load <= cnt_load, prev_up <= cnt_up, hist_vld <= 1. These are the controls that produced the current cnt_in.
- Up-wrap: hist_vld & !prev_load & prev_up & prev_cnt == all-ones & cnt_in == 0.
- Down-wrap: hist_vld & !prev_load & !prev_up & prev_cnt == 0 & cnt_in == all-ones.
- A load of 0 or all-ones is never a wrap, regardless of values.
- Filtered wrap (fwrap) = (up-wrap & dir_q[0]) | (down-wrap & dir_q[1]).
- FSM states: IDLE, ARMED, REPORT.
- IDLE: arm -> ARMED. Clear evt_count and overflow, latch thresh_q/dir_q. If thresh == 0, go to REPORT instead.
- ARMED: fwrap -> evt_count+1. If the new value == thresh_q, go to REPORT. arm -> restart as in IDLE; arm beats a same-cycle fwrap (wrap discarded).
- REPORT: evt_valid=1, evt_count frozen; fwrap sets overflow; arm ignored; evt_valid & evt_ready -> IDLE.
- evt_ready outside REPORT: ignored.
- evt_count cannot exceed thresh_q (≤ 2^EVT_W−1), so there is no wrap of evt_count.

## Timing
- Reset values: evt_valid 0, evt_count 0, wrap_up 0, wrap_dn 0, overflow 0, state IDLE, hist_vld 0, dir_q 00, thresh_q 0.
- First cycle after reset deassertion: no detection (hist_vld 0).
- wrap_up/wrap_dn: registered, high the cycle after cnt_in shows the wrapped value (latency 1).
- evt_count update and REPORT entry: same edge that registers the wrap pulse. evt_valid rises the cycle the wrap pulse is high.
- arm→REPORT with thresh 0: evt_valid high 1 cycle after arm.
- Handshake: completes on any edge with evt_valid & evt_ready. evt_valid low the next cycle. A new arm is accepted one cycle later (IDLE).
- Reset mid-operation: all state returns to reset values immediately; pending report lost.

## Structure
- Package count_mon_pkg: state enum (IDLE, ARMED, REPORT), dir_sel encodings DIR_NONE/DIR_UP/DIR_DN/DIR_BOTH, default CNT_W/EVT_W constants.
- Sub-module wrap_detect: history registers, hist_vld, up/down-wrap compare, registered pulses. Top holds FSM, evt_count, thresh_q, dir_q, overflow.

## Test plan
- Counter loaded to 13, counts up with dir_sel 01, thresh 2 → wrap_up at 15→0 twice (16 cycles apart); evt_valid after the second, evt_count 2.
- Load 15 then load 0 (cnt_load high both cycles) → no wrap_up. Load 0 then count down → wrap_dn once at 0→15.
- dir_sel 10, counter counting up through several wraps → wrap_up pulses but evt_count stays 0, no evt_valid.
- arm with thresh 0 → evt_valid 1 cycle later, evt_count 0. Hold evt_ready low, force an up-wrap with dir_sel 11 → overflow 1, evt_count still 0.
- arm in the same cycle a filtered wrap is detected → evt_count 0 after the edge; the next wrap gives evt_count 1.
- rst asserted while in REPORT with overflow 1 → all outputs 0 immediately. First cnt_in after release with prev value 15/current 0 → no wrap pulse.
